// File: rtl/calc_ctrl_p_pkg.sv
// Shared encodings for the calc_ctrl_p sequencer: operation codes and FSM states.
package calc_pkg;

  // Operation codes captured in LOAD_A.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  // Controller states; the encoding is visible on the cs debug output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MUL    = 3'd5,
    ST_WB     = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

endpackage

// File: rtl/calc_ctrl_p_if.sv
// Command/status bundle between a requester and the calc_ctrl_p sequencer.
interface calc_ctrl_p_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          go;
  logic [2:0]    op;
  logic          acc_mode;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [AW-1:0] rd_idx;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          ovf;
  logic          err;
  logic [2:0]    cs;
  logic [W-1:0]  hist_data;
  logic [AW:0]   hist_cnt;

  // Sequencer side.
  modport slave (
    input  go, op, acc_mode, a_in, b_in, rd_idx,
    output busy, done, result, ovf, err, cs, hist_data, hist_cnt
  );

  // Requester side.
  modport master (
    output go, op, acc_mode, a_in, b_in, rd_idx,
    input  busy, done, result, ovf, err, cs, hist_data, hist_cnt
  );

endinterface

// File: rtl/calc_ctrl_p_hist.sv
// Result-history ring: pushes at write-back, saturating count, newest-first
// indexed read. Storage is not reset; the count masks stale entries.
module calc_hist #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic [AW-1:0] i_rd_idx,
  output logic [W-1:0]  o_data,
  output logic [AW:0]   o_cnt
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_cnt;
  logic [AW-1:0] w_raddr;

  // Storage write at the write pointer; a push coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_rst) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Write pointer wraps naturally (DEPTH is a power of two); count saturates at DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_cnt  <= '0;
    end else if (i_push) begin
      r_wptr <= r_wptr + AW'(1);
      if (r_cnt != (AW+1)'(DEPTH)) begin
        r_cnt <= r_cnt + (AW+1)'(1);
      end
    end
  end

  // Index 0 is the most recent entry; indices beyond the valid count read as zero.
  always_comb begin
    w_raddr = r_wptr - AW'(1) - i_rd_idx;
    if ({1'b0, i_rd_idx} < r_cnt) begin
      o_data = r_mem[w_raddr];
    end else begin
      o_data = '0;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/calc_ctrl_p.sv
// calc_ctrl_p: multi-cycle calculator sequencer. Loads two operands, decodes
// the op, executes in one cycle (or W cycles of shift-add for multiply),
// writes back result/flag and pushes the result into a history ring.
module calc_ctrl_p
  import calc_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  calc_ctrl_p_if.slave  io_bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(W);
  localparam int CW = $clog2(W) + 1;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [2:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_tmp;
  logic            r_tmp_ovf;
  logic [2*W-1:0]  r_mcand;
  logic [W-1:0]    r_mplier;
  logic [2*W-1:0]  r_prod;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_result;
  logic            r_ovf;
  logic            r_err;
  logic            r_busy;
  logic            r_done;

  logic [W:0]      w_sum;
  logic [2*W-1:0]  w_shl;
  logic [W-1:0]    w_alu_res;
  logic            w_alu_ovf;
  logic [2*W-1:0]  w_prod_nxt;
  logic            w_push;
  logic [W-1:0]    w_hist_data;
  logic [AW:0]     w_hist_cnt;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; go is only looked at in IDLE so requests while busy are dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.go) begin
          w_state_nxt = ST_LOAD_A;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD_A: w_state_nxt = ST_LOAD_B;
      ST_LOAD_B: w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (r_op == OP_MUL) begin
          w_state_nxt = ST_MUL;
        end else if (r_op == OP_ILL) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: w_state_nxt = ST_WB;
      ST_MUL: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = ST_WB;
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      ST_WB:   w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle ALU for every op except multiply; flags follow the op semantics.
  always_comb begin
    w_sum     = {1'b0, r_a} + {1'b0, r_b};
    w_shl     = {{W{1'b0}}, r_a} << r_b[SW-1:0];
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu_res = w_sum[W-1:0];
        w_alu_ovf = w_sum[W];
      end
      OP_SUB: begin
        w_alu_res = r_a - r_b;
        w_alu_ovf = (r_a < r_b);
      end
      OP_AND:  w_alu_res = r_a & r_b;
      OP_OR:   w_alu_res = r_a | r_b;
      OP_XOR:  w_alu_res = r_a ^ r_b;
      OP_SHL: begin
        w_alu_res = w_shl[W-1:0];
        w_alu_ovf = |w_shl[2*W-1:W];
      end
      default: begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
      end
    endcase
  end

  // Shift-add step: accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    if (r_mplier[0]) begin
      w_prod_nxt = r_prod + r_mcand;
    end else begin
      w_prod_nxt = r_prod;
    end
  end

  // Datapath registers: operand capture, execute/multiply temporaries, write-back.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op      <= 3'b000;
      r_a       <= '0;
      r_b       <= '0;
      r_tmp     <= '0;
      r_tmp_ovf <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD_A: begin
          r_op <= io_bus.op;
          r_a  <= io_bus.acc_mode ? r_result : io_bus.a_in;
        end
        ST_LOAD_B: begin
          r_b <= io_bus.b_in;
        end
        ST_DECODE: begin
          r_prod   <= '0;
          r_mcand  <= {{W{1'b0}}, r_a};
          r_mplier <= r_b;
          r_cnt    <= CW'(W);
          if (r_op == OP_ILL) begin
            r_err <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_tmp     <= w_alu_res;
          r_tmp_ovf <= w_alu_ovf;
        end
        ST_MUL: begin
          // The temporary tracks the running product so the last step leaves the final value.
          r_prod    <= w_prod_nxt;
          r_mcand   <= {r_mcand[2*W-2:0], 1'b0};
          r_mplier  <= {1'b0, r_mplier[W-1:1]};
          r_cnt     <= r_cnt - CW'(1);
          r_tmp     <= w_prod_nxt[W-1:0];
          r_tmp_ovf <= |w_prod_nxt[2*W-1:W];
        end
        ST_WB: begin
          r_result <= r_tmp;
          r_ovf    <= r_tmp_ovf;
          r_err    <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Status flags registered from the next state so they line up with cs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign w_push = (r_state == ST_WB);

  calc_hist #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_hist (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_push   (w_push),
    .i_data   (r_tmp),
    .i_rd_idx (io_bus.rd_idx),
    .o_data   (w_hist_data),
    .o_cnt    (w_hist_cnt)
  );

  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.result    = r_result;
  assign io_bus.ovf       = r_ovf;
  assign io_bus.err       = r_err;
  assign io_bus.cs        = r_state;
  assign io_bus.hist_data = w_hist_data;
  assign io_bus.hist_cnt  = w_hist_cnt;

endmodule

// File: tb/tb_calc_ctrl_p.sv
// Scoreboard bench for calc_ctrl_p (W=8, DEPTH=4): stimulus tasks queue the
// expected response; a monitor checks it whenever done pulses.
module tb_calc_ctrl_p;
  import calc_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  int   cyc;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       err;
    int         lat;
    int         t0;
    int         cnt;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  calc_ctrl_p_if #(.W(8), .DEPTH(4)) bus();

  calc_ctrl_p #(.W(8), .DEPTH(4)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number: during cycle k (after the k-th rising edge) cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare each time the DUT signals completion.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
      end else begin
        m_e = q.pop_front();
        chk("result",   {24'd0, bus.result},   {24'd0, m_e.res});
        chk("ovf",      {31'd0, bus.ovf},      {31'd0, m_e.ovf});
        chk("err",      {31'd0, bus.err},      {31'd0, m_e.err});
        chk("hist_cnt", {29'd0, bus.hist_cnt}, m_e.cnt);
        chk("latency",  cyc - m_e.t0,          m_e.lat);
      end
    end
  end

  // Issue one operation from IDLE, queue its expectation, wait (bounded) for done.
  task automatic do_op(input logic [2:0] op, input logic acc, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] er, input logic eo,
                       input logic ee, input int lat, input int cnt, input bit pulse);
    exp_t e;
    bit   seen;
    bit   busy_ok;
    @(negedge clk);
    bus.op       = op;
    bus.acc_mode = acc;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.go       = 1'b1;
    e.res = er;
    e.ovf = eo;
    e.err = ee;
    e.lat = lat;
    e.t0  = cyc;
    e.cnt = cnt;
    q.push_back(e);
    busy_ok = (bus.busy === 1'b0);
    seen    = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      bus.go = (pulse && (i == 2 || i == 4)) ? 1'b1 : 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.go = 1'b0;
    chk("busy_window", {31'd0, busy_ok}, 32'd1);
    if (!seen) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: got no done within 40 cycles expected done at +%0d", lat);
      if (q.size() > 0) q.delete(q.size() - 1);
    end
  endtask

  task automatic chk_hist(input logic [1:0] idx, input logic [7:0] exp);
    @(negedge clk);
    bus.rd_idx = idx;
    #1;
    chk("hist_data", {24'd0, bus.hist_data}, {24'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100us");
    $fatal(1);
  end

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    cyc          = 0;
    rst          = 1'b1;
    bus.go       = 1'b0;
    bus.op       = 3'b000;
    bus.acc_mode = 1'b0;
    bus.a_in     = 8'd0;
    bus.b_in     = 8'd0;
    bus.rd_idx   = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_cs",        {29'd0, bus.cs},        32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_done",      {31'd0, bus.done},      32'd0);
    chk("rst_result",    {24'd0, bus.result},    32'd0);
    chk("rst_ovf_err",   {30'd0, bus.ovf, bus.err}, 32'd0);
    chk("rst_hist_cnt",  {29'd0, bus.hist_cnt},  32'd0);
    chk("rst_hist_data", {24'd0, bus.hist_data}, 32'd0);
    rst = 1'b0;

    // Basic latency, carry, multiply, illegal op.
    do_op(OP_ADD, 1'b0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 6,  1, 1'b0);
    do_op(OP_MUL, 1'b0, 8'd15,  8'd17,  8'd255, 1'b0, 1'b0, 13, 2, 1'b0);
    do_op(OP_MUL, 1'b0, 8'd16,  8'd16,  8'd0,   1'b1, 1'b0, 13, 3, 1'b0);
    do_op(OP_ILL, 1'b0, 8'd1,   8'd2,   8'd0,   1'b1, 1'b1, 4,  3, 1'b0);
    // Legal op clears err; go pulses while busy must not start another op.
    do_op(OP_ADD, 1'b0, 8'd5,   8'd3,   8'd8,   1'b0, 1'b0, 6,  4, 1'b1);
    // Accumulator mode: A = 8, a_in ignored.
    do_op(OP_SUB, 1'b1, 8'd99,  8'd10,  8'd254, 1'b1, 1'b0, 6,  4, 1'b0);
    chk_hist(2'd0, 8'd254);
    chk_hist(2'd1, 8'd8);
    chk_hist(2'd2, 8'd0);
    chk_hist(2'd3, 8'd255);

    // Remaining op codes and flag edges.
    do_op(OP_AND, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 6, 4, 1'b0);
    do_op(OP_OR,  1'b0, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 6, 4, 1'b0);
    do_op(OP_XOR, 1'b0, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 6, 4, 1'b0);
    do_op(OP_SHL, 1'b0, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 6, 4, 1'b0);
    do_op(OP_SHL, 1'b0, 8'h0F, 8'h0B, 8'h78, 1'b0, 1'b0, 6, 4, 1'b0);
    do_op(OP_SUB, 1'b0, 8'd10, 8'd3,  8'd7,  1'b0, 1'b0, 6, 4, 1'b0);
    do_op(OP_ADD, 1'b0, 8'h80, 8'h7F, 8'hFF, 1'b0, 1'b0, 6, 4, 1'b0);

    // History wrap: five results 1..5.
    for (int k = 1; k <= 5; k++) begin
      do_op(OP_ADD, 1'b0, 8'(k - 1), 8'd1, 8'(k), 1'b0, 1'b0, 6, 4, 1'b0);
    end
    chk_hist(2'd0, 8'd5);
    chk_hist(2'd3, 8'd2);

    // Reset in the third MUL cycle aborts the op.
    @(negedge clk);
    bus.op       = OP_MUL;
    bus.acc_mode = 1'b0;
    bus.a_in     = 8'd7;
    bus.b_in     = 8'd9;
    bus.go       = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_cs_mul", {29'd0, bus.cs}, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs",       {29'd0, bus.cs},       32'd0);
    chk("abort_busy",     {31'd0, bus.busy},     32'd0);
    chk("abort_result",   {24'd0, bus.result},   32'd0);
    chk("abort_hist_cnt", {29'd0, bus.hist_cnt}, 32'd0);
    rst = 1'b0;
    do_op(OP_ADD, 1'b0, 8'd2, 8'd2, 8'd4, 1'b0, 1'b0, 6, 1, 1'b0);
    chk_hist(2'd0, 8'd4);
    chk_hist(2'd1, 8'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/calc_ctrl_p.md
CALC_CTRL_P -- requirements
Module: calc_ctrl_p

Interface
REQ-001 Parameter W, 8, operand/result width (>=4).
REQ-002 Parameter DEPTH, 4, result-history entries (power of 2, >=2).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 go  in  1  start request; sampled only in IDLE.
REQ-006 op  in  3  operation code; captured in LOAD_A.
REQ-007 acc_mode  in  1  1 = operand A taken from result register instead of a_in.
REQ-008 a_in, b_in  in  W each  operands, captured in LOAD_A / LOAD_B respectively.
REQ-009 rd_idx  in  $clog2(DEPTH)  history read index; 0 = most recent.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse, high only in DONE.
REQ-012 result  out  W  last written-back result (registered).
REQ-013 ovf  out  1  overflow/carry flag of last written-back op.
REQ-014 err  out  1  last accepted op was illegal.
REQ-015 cs  out  3  current state encoding (debug).
REQ-016 hist_data  out  W  history entry at rd_idx (combinational); hist_cnt  out  $clog2(DEPTH)+1  valid entries.

Function
REQ-017 States: IDLE=0, LOAD_A=1, LOAD_B=2, DECODE=3, EXEC=4, MUL=5, WB=6, DONE=7.
REQ-018 IDLE->LOAD_A when go=1, else stay; go in any other state ignored, not queued.
REQ-019 LOAD_A->LOAD_B; at exit edge capture op, acc_mode, A = acc_mode ? result : a_in.
REQ-020 LOAD_B->DECODE; at exit edge capture B = b_in.
REQ-021 DECODE: op 101 -> MUL (load bit counter = W); op 111 -> DONE with err=1; else -> EXEC.
REQ-022 Ops: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 A*B low W bits, 110 A<<B[$clog2(W)-1:0].
REQ-023 EXEC: one cycle, registers temp result and flag, -> WB.
REQ-024 MUL: shift-add, one multiplier bit per cycle, exactly W cycles, then -> WB.
REQ-025 ovf: add carry-out; sub borrow (A<B); mul upper W bits nonzero; shl any 1 shifted out; logic ops 0.
REQ-026 WB: result, ovf updated, err cleared, history push, -> DONE.
REQ-027 DONE: done=1, -> IDLE.
REQ-028 Latency (go high in IDLE cycle 0): done in cycle 6 single-cycle ops, cycle 5+W for mul, cycle 4 for illegal op.
REQ-029 Illegal op: result, ovf, history unchanged; err stays 1 until next WB or reset.
REQ-030 History: DEPTH-entry ring; push at WB; hist_cnt saturates at DEPTH; when full, oldest entry overwritten.
REQ-031 hist_data = 0 when rd_idx >= hist_cnt.

Reset
REQ-032 rst=1 at any edge, including mid-operation: cs=IDLE, busy=0, done=0, result=0, ovf=0, err=0, hist_cnt=0; operation aborted, no write-back.
REQ-033 History storage need not be cleared; hist_cnt=0 makes it unreadable.

Structure
REQ-034 Package calc_pkg holds op codes and state encodings; no other shared items.
REQ-035 Sub-module calc_hist implements the history ring (push, wrap, count, indexed read).

Verification (W=8, DEPTH=4)
REQ-036 add 200+100, go cycle 0 -> done cycle 6, result=44, ovf=1, busy high cycles 1-6.
REQ-037 mul 15*17 -> result=255, ovf=0, done cycle 13; mul 16*16 -> result=0, ovf=1.
REQ-038 op=111 -> done cycle 4, err=1, result and hist_cnt unchanged; next legal op clears err.
REQ-039 add 5+3 -> 8; then acc_mode=1 sub b_in=10 -> result=254, ovf=1; go pulses during busy ignored.
REQ-040 five add ops with results 1..5 -> hist_cnt=4, rd_idx 0->5, rd_idx 3->2.
REQ-041 rst asserted in 3rd MUL cycle -> next cycle cs=0, busy=0, result=0, hist_cnt=0; following add 2+2 -> 4.
